// File: rtl/vuvmu_roq_alloc.sv
// Reorder queue tag allocator: hands out slot tags in order, accepts out-of-order
// responses into those slots, and releases data strictly in allocation order.
module vuvmu_roq_alloc #(
  parameter int ROQ_DATA_SIZE   = 128,
  parameter int ROQ_TAG_ENTRIES = 8,
  parameter int ROQ_TAG_SIZE    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     roq_tag_val,
  input  logic                     roq_tag_rdy,
  output logic [ROQ_TAG_SIZE-1:0]  roq_tag_bits,
  input  logic                     roq_enq_val,
  input  logic [ROQ_TAG_SIZE-1:0]  roq_enq_tag_bits,
  input  logic [ROQ_DATA_SIZE-1:0] roq_enq_data_bits,
  output logic                     roq_deq_data_val,
  input  logic                     roq_deq_data_rdy,
  output logic [ROQ_DATA_SIZE-1:0] roq_deq_data_bits,
  output logic [ROQ_TAG_SIZE:0]    roq_count,
  output logic                     roq_err
);

  localparam logic [ROQ_TAG_SIZE:0]    ENTRIES_C   = (ROQ_TAG_SIZE+1)'(ROQ_TAG_ENTRIES);
  localparam logic [ROQ_TAG_SIZE:0]    COUNT_ONE_C = (ROQ_TAG_SIZE+1)'(1);
  localparam logic [ROQ_TAG_SIZE-1:0]  PTR_ONE_C   = (ROQ_TAG_SIZE)'(1);
  localparam logic [ROQ_TAG_ENTRIES-1:0] SLOT_ONE_C = (ROQ_TAG_ENTRIES)'(1);

  logic [ROQ_TAG_SIZE-1:0]    alloc_ptr_r;
  logic [ROQ_TAG_SIZE-1:0]    read_ptr_r;
  logic [ROQ_TAG_SIZE-1:0]    read_ptr_nxt_s;
  logic [ROQ_TAG_SIZE-1:0]    enq_off_s;
  logic [ROQ_TAG_SIZE:0]      count_r;
  logic [ROQ_TAG_SIZE:0]      count_nxt_s;
  logic [ROQ_TAG_ENTRIES-1:0] valid_r;
  logic [ROQ_TAG_ENTRIES-1:0] valid_nxt_s;
  logic [ROQ_TAG_ENTRIES-1:0] deq_mask_s;
  logic [ROQ_TAG_ENTRIES-1:0] enq_mask_s;
  logic [ROQ_DATA_SIZE-1:0]   data_r [ROQ_TAG_ENTRIES];
  logic                       deq_val_r;
  logic                       deq_val_nxt_s;
  logic                       err_r;
  logic                       alloc_fire_s;
  logic                       deq_fire_s;
  logic                       enq_legal_s;
  logic                       enq_bad_s;

  assign roq_tag_val       = (count_r < ENTRIES_C) && !reset;
  assign roq_tag_bits      = alloc_ptr_r;
  assign roq_deq_data_val  = deq_val_r;
  assign roq_deq_data_bits = data_r[read_ptr_r];
  assign roq_count         = count_r;
  assign roq_err           = err_r;

  // Handshakes, enqueue legality against the pre-update window, and next-state values
  always_comb begin
    alloc_fire_s = roq_tag_val && roq_tag_rdy;
    deq_fire_s   = deq_val_r && roq_deq_data_rdy;
    // Distance from the head; only slots inside the allocated window may be written
    enq_off_s    = roq_enq_tag_bits - read_ptr_r;
    enq_legal_s  = roq_enq_val && ({1'b0, enq_off_s} < count_r) && !valid_r[roq_enq_tag_bits];
    enq_bad_s    = roq_enq_val && !enq_legal_s;
    deq_mask_s   = {ROQ_TAG_ENTRIES{deq_fire_s}} & (SLOT_ONE_C << read_ptr_r);
    enq_mask_s   = {ROQ_TAG_ENTRIES{enq_legal_s}} & (SLOT_ONE_C << roq_enq_tag_bits);
    valid_nxt_s  = (valid_r & ~deq_mask_s) | enq_mask_s;
    if (deq_fire_s) begin
      read_ptr_nxt_s = read_ptr_r + PTR_ONE_C;
    end else begin
      read_ptr_nxt_s = read_ptr_r;
    end
    case ({alloc_fire_s, deq_fire_s})
      2'b10:   count_nxt_s = count_r + COUNT_ONE_C;
      2'b01:   count_nxt_s = count_r - COUNT_ONE_C;
      default: count_nxt_s = count_r;
    endcase
    deq_val_nxt_s = valid_nxt_s[read_ptr_nxt_s];
  end

  // Control state: pointers, occupancy, slot valid bits, head-valid register, sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr_r <= '0;
      read_ptr_r  <= '0;
      count_r     <= '0;
      valid_r     <= '0;
      deq_val_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (alloc_fire_s) begin
        alloc_ptr_r <= alloc_ptr_r + PTR_ONE_C;
      end
      read_ptr_r <= read_ptr_nxt_s;
      count_r    <= count_nxt_s;
      valid_r    <= valid_nxt_s;
      deq_val_r  <= deq_val_nxt_s;
      err_r      <= err_r || enq_bad_s;
    end
  end

  // Response data storage; contents are qualified by the valid bits so need no reset
  always_ff @(posedge clk) begin
    if (enq_legal_s) begin
      data_r[roq_enq_tag_bits] <= roq_enq_data_bits;
    end
  end

endmodule

// File: doc/vuvmu_roq_alloc.md
VUVMU_ROQ_ALLOC -- requirements
Module: vuvmu_roq_alloc

Interface
REQ-001 SHALL have parameter ROQ_DATA_SIZE, default 128, response data width in bits.
REQ-002 SHALL have parameter ROQ_TAG_ENTRIES, default 8, number of reorder slots; a power of two, at least 2.
REQ-003 SHALL have parameter ROQ_TAG_SIZE, default 3, equal to log2(ROQ_TAG_ENTRIES).
REQ-004 SHALL use a single clock and a synchronous, active-high reset, with ports as listed below.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 roq_tag_val  output  1  a free tag is available for allocation.
REQ-008 roq_tag_rdy  input  1  requester takes the offered tag this cycle.
REQ-009 roq_tag_bits  output  ROQ_TAG_SIZE  tag offered for allocation.
REQ-010 roq_enq_val  input  1  D$ response valid this cycle.
REQ-011 roq_enq_tag_bits  input  ROQ_TAG_SIZE  slot tag of the response.
REQ-012 roq_enq_data_bits  input  ROQ_DATA_SIZE  response data.
REQ-013 roq_deq_data_val  output  1  in-order head data valid (registered).
REQ-014 roq_deq_data_rdy  input  1  writeback consumes head.
REQ-015 roq_deq_data_bits  output  ROQ_DATA_SIZE  data of the head slot.
REQ-016 roq_count  output  ROQ_TAG_SIZE+1  allocated-but-not-dequeued slot count, 0..ROQ_TAG_ENTRIES.
REQ-017 roq_err  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL hold alloc_ptr and read_ptr, ROQ_TAG_SIZE bits each, wrapping modulo ROQ_TAG_ENTRIES, plus a per-slot valid-bit array and a data array.
REQ-019 roq_tag_bits SHALL equal alloc_ptr; roq_tag_val SHALL be (roq_count < ROQ_TAG_ENTRIES) and not reset.
REQ-020 Alloc fire = roq_tag_val & roq_tag_rdy; on fire, alloc_ptr increments and count increments.
REQ-021 Deq fire = roq_deq_data_val & roq_deq_data_rdy; on fire, the valid bit of slot read_ptr clears, read_ptr increments and count decrements.
REQ-022 Simultaneous alloc fire and deq fire SHALL leave count unchanged while both pointers advance.
REQ-023 An enqueue is legal iff ((roq_enq_tag_bits - read_ptr) mod ROQ_TAG_ENTRIES) < roq_count and that slot's valid bit is clear, evaluated before this cycle's updates.
REQ-024 A legal enqueue SHALL write the data and set the valid bit at the clock edge.
REQ-025 An illegal enqueue SHALL be dropped (no data or valid write) and SHALL set roq_err, which stays set until reset.
REQ-026 Enqueueing to read_ptr in the same cycle as a deq fire is illegal (slot still valid); it SHALL be dropped and flagged, and the valid bit SHALL clear.
REQ-027 roq_deq_data_val SHALL be registered: next value = post-update valid bit of post-update read_ptr, including this cycle's enqueue and dequeue.
REQ-028 Enqueue-to-dequeue latency: a legal enqueue to the head slot at edge t SHALL give roq_deq_data_val=1 in the cycle after edge t.
REQ-029 Back-to-back: with head and head+1 both valid and rdy held high, roq_deq_data_val SHALL stay 1 and one entry SHALL retire per cycle.
REQ-030 roq_deq_data_bits SHALL be data[read_ptr] combinationally; its value is don't-care while roq_deq_data_val=0.
REQ-031 Full (count=ROQ_TAG_ENTRIES): roq_tag_val=0; a deq fire in that cycle SHALL NOT make an allocation possible until the next cycle.
REQ-032 Empty (count=0): every enqueue is illegal and roq_deq_data_val=0.

Reset
REQ-033 On reset the block SHALL set read_ptr=0, alloc_ptr=0, all valid bits=0, roq_count=0, roq_deq_data_val=0 and roq_err=0; data contents are not reset.
REQ-034 Reset SHALL take priority over all concurrent alloc, enq and deq activity, and asserting reset mid-operation discards all outstanding entries.
REQ-035 While reset is high, roq_tag_val SHALL be 0.

Verification (ROQ_TAG_ENTRIES=8, ROQ_DATA_SIZE=128)
REQ-036 Allocate tags 0..7 with rdy=1 -> roq_tag_bits steps 0..7, roq_count reaches 8, and roq_tag_val=0 on the cycle after the 8th fire.
REQ-037 With 4 tags allocated, enqueue tags 3,1,2,0 with data 0xD3,0xD1,0xD2,0xD0 and rdy=1 -> dequeue order 0xD0,0xD1,0xD2,0xD3; roq_deq_data_val first rises the cycle after the tag-0 enqueue, then holds 1 for four consecutive cycles.
REQ-038 Wrap: run 20 alloc/enq/deq triples -> tags wrap 7->0, data stays in order, roq_count returns to 0 and roq_err=0.
REQ-039 Enqueue to tag 5 with roq_count=2 and read_ptr=0 -> roq_err=1, no valid bit is set, and roq_count is unchanged; a duplicate enqueue to an already-valid tag also sets roq_err.
REQ-040 Full window plus deq fire plus alloc attempt in the same cycle -> no alloc that cycle and roq_count=7; the next cycle allocates tag 0 (wrapped) and roq_count=8.
REQ-041 Assert reset with 3 entries valid -> next cycle roq_deq_data_val=0, roq_count=0, roq_tag_bits=0, roq_err=0.
